alu_exec_wb: RTL and testbench

//   Execute/writeback stage wrapped around the 19-bit combinational ALU.

---
 rtl/alu_exec_wb.sv | 119 +++++++++++
 tb/tb_alu_exec_wb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_wb.sv
// Execute/writeback stage around a 19-bit combinational ALU: registers one op into the ALU,
// captures the 38-bit result, then writes it back (two beats for MUL), flagging DIV/0 and illegal ops.
module alu_exec_wb #(
  parameter int DATA_W = 19,
  parameter int OP_W   = 5,
  parameter int RA_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_opcode,
  input  logic [RA_W-1:0]     in_rd,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_opcode,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                wb_en,
  output logic [RA_W-1:0]     wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic                flag_zero,
  output logic                flag_dz,
  output logic                flag_ill,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, EXEC, WB_LO, WB_HI} state_t;

  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LAST = OP_W'(9);

  state_t              state_q, state_d;
  logic [RA_W-1:0]     rd_q;
  logic [2*DATA_W-1:0] res_q;
  logic                mul_q;
  logic                accept;
  logic                suppress;
  logic                go_hi;
  logic                exec_mul;

  assign accept   = in_valid && in_ready;
  assign suppress = flag_dz || flag_ill;
  // A legal MUL needs a second writeback beat, so WB_LO cannot hand over to a new op.
  assign go_hi    = mul_q && !suppress;
  assign exec_mul = (alu_opcode == OP_MUL);

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    wb_en    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_d = EXEC;
      end
      EXEC: state_d = WB_LO;
      WB_LO: begin
        wb_en   = !suppress;
        wb_addr = rd_q;
        wb_data = res_q[DATA_W-1:0];
        if (go_hi) begin
          state_d = WB_HI;
        end else begin
          in_ready = 1'b1;
          done     = 1'b1;
          state_d  = accept ? EXEC : IDLE;
        end
      end
      WB_HI: begin
        in_ready = 1'b1;
        wb_en    = 1'b1;
        wb_addr  = rd_q + RA_W'(1);
        wb_data  = res_q[2*DATA_W-1:DATA_W];
        done     = 1'b1;
        state_d  = accept ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rd_q       <= '0;
      res_q      <= '0;
      mul_q      <= 1'b0;
      flag_zero  <= 1'b0;
      flag_dz    <= 1'b0;
      flag_ill   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a      <= in_a;
        alu_b      <= in_b;
        alu_opcode <= in_opcode;
        rd_q       <= in_rd;
      end
      if (state_q == EXEC) begin
        res_q     <= alu_result;
        mul_q     <= exec_mul;
        flag_zero <= exec_mul ? (alu_result == '0) : (alu_result[DATA_W-1:0] == '0);
        flag_dz   <= (alu_opcode == OP_DIV) && (alu_b == '0);
        flag_ill  <= (alu_opcode > OP_LAST);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_wb.sv
// Scoreboard bench for alu_exec_wb: a behavioural ALU closes the loop, expected writes are
// queued by the stimulus and popped by a monitor whenever wb_en is seen.
module tb_alu_exec_wb;

  localparam int DATA_W = 19;
  localparam int OP_W   = 5;
  localparam int RA_W   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     in_opcode;
  logic [RA_W-1:0]     in_rd;
  logic [DATA_W-1:0]   in_a, in_b;
  logic [DATA_W-1:0]   alu_a, alu_b;
  logic [OP_W-1:0]     alu_opcode;
  logic [2*DATA_W-1:0] alu_result;
  logic                wb_en;
  logic [RA_W-1:0]     wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic                flag_zero, flag_dz, flag_ill, done;

  typedef struct packed {
    logic [RA_W-1:0]   addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  done_cnt = 0;
  int  cyc = 0;
  int  prev_wr_cyc = 0;
  int  wr_gap = 0;

  always #5 clk = ~clk;

  alu_exec_wb #(.DATA_W(DATA_W), .OP_W(OP_W), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_zero(flag_zero), .flag_dz(flag_dz), .flag_ill(flag_ill), .done(done)
  );

  // Behavioural ALU standing in for the real combinational block.
  always_comb begin
    logic [2*DATA_W-1:0] ax, bx;
    ax = {{DATA_W{1'b0}}, alu_a};
    bx = {{DATA_W{1'b0}}, alu_b};
    alu_result = '0;
    case (alu_opcode)
      5'd0: alu_result = ax + bx;
      5'd1: alu_result = ax - bx;
      5'd2: alu_result = ax * bx;
      5'd3: alu_result = (bx == '0) ? '0 : ax / bx;
      5'd4: alu_result = ax + 1;
      5'd5: alu_result = ax - 1;
      5'd6: alu_result = ax & bx;
      5'd7: alu_result = ax | bx;
      5'd8: alu_result = ax ^ bx;
      5'd9: alu_result = {{DATA_W{1'b0}}, ~alu_a};
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wb_en) begin
      wr_gap      = cyc - prev_wr_cyc;
      prev_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {wb_addr, wb_data}, 64'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wb_addr", wb_addr, e.addr);
        check("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic expect_wr(input int addr, input int data);
    wr_t e;
    e.addr = RA_W'(addr);
    e.data = DATA_W'(data);
    exp_q.push_back(e);
  endtask

  // Drive an op and return #1 after the edge that accepted it.
  task automatic send(input int op, input int rd, input int a, input int b);
    int n = 0;
    in_valid  = 1'b1;
    in_opcode = OP_W'(op);
    in_rd     = RA_W'(rd);
    in_a      = DATA_W'(a);
    in_b      = DATA_W'(b);
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("accept_timeout", 64'h0, 64'h1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("done_timeout", 64'h0, 64'h1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_wb_en", wb_en, 0);
    check("rst_done", done, 0);
    check("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    check("rst_flags", {flag_zero, flag_dz, flag_ill}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 1: ADD 1+2 -> r3 = 3
    expect_wr(3, 3);
    send(0, 3, 1, 2); idle();
    wait_done();
    check("add_flag_zero", flag_zero, 0);
    @(posedge clk); #1;

    // 2: MUL 0x7FFFF^2 -> r15 = 0x00001, r0 = 0x7FFFE; done only on the high beat
    expect_wr(15, 'h00001);
    expect_wr(0, 'h7FFFE);
    send(2, 15, 'h7FFFF, 'h7FFFF); idle();
    @(posedge clk); #1;
    check("mul_lo_done", done, 0);
    check("mul_lo_ready", in_ready, 0);
    @(posedge clk); #1;
    check("mul_hi_done", done, 1);
    check("mul_hi_addr", wb_addr, 0);
    @(posedge clk); #1;

    // 3: DIV by zero suppressed, then DIV 9/3 -> r2 = 3
    send(3, 5, 9, 0); idle();
    wait_done();
    check("dz_flag", flag_dz, 1);
    check("dz_wb_en", wb_en, 0);
    @(posedge clk); #1;
    expect_wr(2, 3);
    send(3, 2, 9, 3); idle();
    wait_done();
    check("div_flag_dz", flag_dz, 0);
    @(posedge clk); #1;

    // 4: valid held: SUB 5-3 -> r1 = 2, DEC 0 -> r4 = 0x7FFFF, writes 2 cycles apart
    expect_wr(1, 2);
    expect_wr(4, 'h7FFFF);
    send(1, 1, 5, 3);
    send(5, 4, 0, 0); idle();
    wait_done();
    check("dec_flag_zero", flag_zero, 0);
    @(posedge clk); #1;
    check("b2b_gap", wr_gap, 2);

    // 5: illegal opcode suppressed, then XOR 5^5 -> r6 = 0, zero flag
    send(20, 7, 1, 1); idle();
    wait_done();
    check("ill_flag", flag_ill, 1);
    check("ill_wb_en", wb_en, 0);
    @(posedge clk); #1;
    expect_wr(6, 0);
    send(8, 6, 5, 5); idle();
    wait_done();
    check("xor_flag_zero", flag_zero, 1);
    check("xor_flag_ill", flag_ill, 0);
    @(posedge clk); #1;

    // 6: reset during EXEC discards the op
    send(0, 9, 4, 4); idle();
    #2 rst = 1'b1;
    #1;
    check("rst6_in_ready", in_ready, 1);
    check("rst6_alu", {alu_a, alu_b, alu_opcode}, 0);
    check("rst6_flags", {flag_zero, flag_dz, flag_ill}, 0);
    check("rst6_wb_en", wb_en, 0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pending_writes", exp_q.size(), 0);
    check("done_count", done_cnt, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
